// File: rtl/pc_sequencer_if.sv
// Bus bundle for the program-counter unit: control/strobe inputs and the
// registered PC-related outputs. The master drives the controls, the slave
// (the sequencer itself) drives the results.
interface pc_sequencer_if #(
  parameter int WIDTH = 12
);
  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] in;
  logic             intreq;
  logic             ionreq;
  logic             iofreq;
  logic             latch;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pclat;
  logic [WIDTH-1:0] saved;
  logic             ien;
  logic             intack;

  modport master (
    output en, op, in, intreq, ionreq, iofreq, latch,
    input  pc, pclat, saved, ien, intack
  );

  modport slave (
    input  en, op, in, intreq, ionreq, iofreq, latch,
    output pc, pclat, saved, ien, intack
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter unit: advances the PC once per instruction strobe, takes
// interrupts (saving the return address and forcing the vector) and owns the
// interrupt-enable flag with its one-instruction ION delay. Every output is a
// flop, so there is no combinational path from the bus inputs to the outputs.
module pc_sequencer #(
  parameter int               WIDTH     = 12,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(12'o0200),
  parameter logic [WIDTH-1:0] INT_VEC   = WIDTH'(12'o0001)
) (
  input  logic          clk,
  input  logic          clr,
  pc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    OP_HOLD    = 3'b000,
    OP_INC     = 3'b001,
    OP_SKIP    = 3'b010,
    OP_LOAD    = 3'b011,
    OP_LOADINC = 3'b100
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pclat_q, pclat_d;
  logic [WIDTH-1:0] saved_q, saved_d;
  logic             ien_q, ien_d;
  logic             ion_pend_q, ion_pend_d;
  logic             intack_q, intack_d;
  logic [WIDTH-1:0] npc;
  logic             int_take;

  // Next-PC selection; arithmetic wraps naturally at WIDTH bits.
  always_comb begin
    npc = pc_q;
    case (bus.op)
      OP_INC:     npc = pc_q + WIDTH'(1);
      OP_SKIP:    npc = pc_q + WIDTH'(2);
      OP_LOAD:    npc = bus.in;
      OP_LOADINC: npc = bus.in + WIDTH'(1);
      default:    npc = pc_q;
    endcase
  end

  // Interrupt is only taken on an instruction strobe with interrupts enabled.
  assign int_take = bus.en && ien_q && bus.intreq;

  // Next-state for PC, saved address, interrupt enable and the ION delay.
  always_comb begin
    pc_d       = pc_q;
    saved_d    = saved_q;
    ien_d      = ien_q;
    ion_pend_d = ion_pend_q;
    intack_d   = 1'b0;
    pclat_d    = bus.latch ? pc_q : pclat_q;

    if (bus.en) begin
      if (int_take) begin
        saved_d    = npc;
        pc_d       = INT_VEC;
        ien_d      = 1'b0;
        ion_pend_d = 1'b0;
        intack_d   = 1'b1;
      end else begin
        pc_d = npc;
        if (ion_pend_q) begin
          // Promotion consumes the pending request; a fresh ION in the same
          // cycle is redundant because IEN becomes 1 anyway.
          ien_d      = 1'b1;
          ion_pend_d = 1'b0;
        end
      end
    end

    // ION arms the delay only while interrupts are off and nothing is
    // being promoted this cycle.
    if (bus.ionreq && !ien_q && !ien_d && !int_take) begin
      ion_pend_d = 1'b1;
    end

    // IOF has the final word over any ION activity in the same cycle.
    if (bus.iofreq) begin
      ien_d      = 1'b0;
      ion_pend_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q       <= RESET_VEC;
      pclat_q    <= RESET_VEC;
      saved_q    <= '0;
      ien_q      <= 1'b0;
      ion_pend_q <= 1'b0;
      intack_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pclat_q    <= pclat_d;
      saved_q    <= saved_d;
      ien_q      <= ien_d;
      ion_pend_q <= ion_pend_d;
      intack_q   <= intack_d;
    end
  end

  assign bus.pc     = pc_q;
  assign bus.pclat  = pclat_q;
  assign bus.saved  = saved_q;
  assign bus.ien    = ien_q;
  assign bus.intack = intack_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 12-bit instance for the main behaviour
// and a 15-bit instance (RESET_VEC=0) for the wider wrap-around case.
module tb_pc_sequencer;

  logic clk;
  logic clr;
  logic clr15;
  int   total;
  int   bad;

  pc_sequencer_if #(.WIDTH(12)) bus ();
  pc_sequencer_if #(.WIDTH(15)) bus15 ();

  pc_sequencer #(
    .WIDTH(12), .RESET_VEC(12'o0200), .INT_VEC(12'o0001)
  ) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );

  pc_sequencer #(
    .WIDTH(15), .RESET_VEC(15'o00000), .INT_VEC(15'o00001)
  ) dut15 (
    .clk(clk), .clr(clr15), .bus(bus15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of 12-bit inputs at a negedge, return at the next negedge.
  task automatic step(input logic e, input logic [2:0] o, input logic [11:0] v,
                      input logic ir, input logic onr, input logic ofr,
                      input logic l);
    bus.en = e; bus.op = o; bus.in = v; bus.intreq = ir;
    bus.ionreq = onr; bus.iofreq = ofr; bus.latch = l;
    @(negedge clk);
  endtask

  task automatic pulse_clr(input logic ir, input logic onr);
    clr = 1'b1;
    step(1'b1, 3'b011, 12'o1234, ir, onr, 1'b0, 1'b1);
    clr = 1'b0;
  endtask

  task automatic test_reset;
    pulse_clr(1'b1, 1'b1);
    total++; if (bus.pc !== 12'o0200) begin bad++; $display("FAIL reset_pc got=%o exp=%o", bus.pc, 12'o0200); end
    total++; if (bus.pclat !== 12'o0200) begin bad++; $display("FAIL reset_pclat got=%o exp=%o", bus.pclat, 12'o0200); end
    total++; if (bus.saved !== 12'o0000) begin bad++; $display("FAIL reset_saved got=%o exp=%o", bus.saved, 12'o0000); end
    total++; if (bus.ien !== 1'b0) begin bad++; $display("FAIL reset_ien got=%b exp=0", bus.ien); end
    total++; if (bus.intack !== 1'b0) begin bad++; $display("FAIL reset_intack got=%b exp=0", bus.intack); end
    for (int i = 0; i < 5; i++) step(1'b1, 3'b001, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pc !== 12'o0205) begin bad++; $display("FAIL inc5_pc got=%o exp=%o", bus.pc, 12'o0205); end
    total++; if (bus.ien !== 1'b0) begin bad++; $display("FAIL inc5_ien got=%b exp=0", bus.ien); end
    total++; if (bus.pclat !== 12'o0200) begin bad++; $display("FAIL inc5_pclat got=%o exp=%o", bus.pclat, 12'o0200); end
    $display("test_reset done pc=%o", bus.pc);
  endtask

  task automatic test_wrap;
    step(1'b1, 3'b011, 12'o7776, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pc !== 12'o7776) begin bad++; $display("FAIL load_pc got=%o exp=%o", bus.pc, 12'o7776); end
    step(1'b1, 3'b010, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pc !== 12'o0000) begin bad++; $display("FAIL skip_wrap got=%o exp=%o", bus.pc, 12'o0000); end
    step(1'b1, 3'b011, 12'o7777, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b001, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pc !== 12'o0000) begin bad++; $display("FAIL inc_wrap got=%o exp=%o", bus.pc, 12'o0000); end
    step(1'b1, 3'b011, 12'o7777, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b010, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pc !== 12'o0001) begin bad++; $display("FAIL skip_wrap1 got=%o exp=%o", bus.pc, 12'o0001); end
    step(1'b1, 3'b100, 12'o7777, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pc !== 12'o0000) begin bad++; $display("FAIL loadinc_wrap got=%o exp=%o", bus.pc, 12'o0000); end
    step(1'b1, 3'b100, 12'o0123, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b101, 12'o7000, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pc !== 12'o0124) begin bad++; $display("FAIL op5_hold got=%o exp=%o", bus.pc, 12'o0124); end
    step(1'b1, 3'b111, 12'o7000, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pc !== 12'o0124) begin bad++; $display("FAIL op7_hold got=%o exp=%o", bus.pc, 12'o0124); end
    $display("test_wrap done pc=%o", bus.pc);
  endtask

  task automatic test_en_low;
    step(1'b1, 3'b011, 12'o0450, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b001, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.pc !== 12'o0450) begin bad++; $display("FAIL en_low_pc[%0d] got=%o exp=%o", i, bus.pc, 12'o0450); end
    end
    step(1'b0, 3'b001, 12'o0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (bus.pclat !== 12'o0450) begin bad++; $display("FAIL latch_pclat got=%o exp=%o", bus.pclat, 12'o0450); end
    step(1'b1, 3'b001, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pclat !== 12'o0450) begin bad++; $display("FAIL latch_hold got=%o exp=%o", bus.pclat, 12'o0450); end
    $display("test_en_low done pc=%o pclat=%o", bus.pc, bus.pclat);
  endtask

  task automatic test_interrupt;
    step(1'b1, 3'b011, 12'o0300, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b001, 12'o0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (bus.pc !== 12'o0301) begin bad++; $display("FAIL int_s1_pc got=%o exp=%o", bus.pc, 12'o0301); end
    total++; if (bus.ien !== 1'b0) begin bad++; $display("FAIL int_s1_ien got=%b exp=0", bus.ien); end
    total++; if (bus.intack !== 1'b0) begin bad++; $display("FAIL int_s1_intack got=%b exp=0", bus.intack); end
    step(1'b1, 3'b001, 12'o0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pc !== 12'o0302) begin bad++; $display("FAIL int_s2_pc got=%o exp=%o", bus.pc, 12'o0302); end
    total++; if (bus.ien !== 1'b1) begin bad++; $display("FAIL int_s2_ien got=%b exp=1", bus.ien); end
    step(1'b0, 3'b001, 12'o0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bus.pc !== 12'o0302) begin bad++; $display("FAIL int_enlow_pc got=%o exp=%o", bus.pc, 12'o0302); end
    total++; if (bus.intack !== 1'b0) begin bad++; $display("FAIL int_enlow_intack got=%b exp=0", bus.intack); end
    step(1'b1, 3'b010, 12'o0, 1'b1, 1'b0, 1'b0, 1'b1);
    total++; if (bus.pc !== 12'o0001) begin bad++; $display("FAIL int_s3_pc got=%o exp=%o", bus.pc, 12'o0001); end
    total++; if (bus.saved !== 12'o0304) begin bad++; $display("FAIL int_s3_saved got=%o exp=%o", bus.saved, 12'o0304); end
    total++; if (bus.ien !== 1'b0) begin bad++; $display("FAIL int_s3_ien got=%b exp=0", bus.ien); end
    total++; if (bus.intack !== 1'b1) begin bad++; $display("FAIL int_s3_intack got=%b exp=1", bus.intack); end
    total++; if (bus.pclat !== 12'o0302) begin bad++; $display("FAIL int_s3_pclat got=%o exp=%o", bus.pclat, 12'o0302); end
    step(1'b1, 3'b001, 12'o0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bus.intack !== 1'b0) begin bad++; $display("FAIL int_after_intack got=%b exp=0", bus.intack); end
    total++; if (bus.pc !== 12'o0002) begin bad++; $display("FAIL int_after_pc got=%o exp=%o", bus.pc, 12'o0002); end
    total++; if (bus.saved !== 12'o0304) begin bad++; $display("FAIL int_after_saved got=%o exp=%o", bus.saved, 12'o0304); end
    $display("test_interrupt done pc=%o saved=%o", bus.pc, bus.saved);
  endtask

  task automatic test_ion_iof;
    step(1'b1, 3'b001, 12'o0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'b001, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b001, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.ien !== 1'b0) begin bad++; $display("FAIL ion_iof_same got=%b exp=0", bus.ien); end
    step(1'b1, 3'b001, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b001, 12'o0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 3'b001, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.ien !== 1'b0) begin bad++; $display("FAIL iof_vs_promote got=%b exp=0", bus.ien); end
    step(1'b1, 3'b001, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b001, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.ien !== 1'b1) begin bad++; $display("FAIL ion_delay got=%b exp=1", bus.ien); end
    step(1'b0, 3'b000, 12'o0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (bus.ien !== 1'b0) begin bad++; $display("FAIL iof_clear got=%b exp=0", bus.ien); end
    $display("test_ion_iof done ien=%b", bus.ien);
  endtask

  task automatic test_clr_mid;
    step(1'b1, 3'b001, 12'o0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_clr(1'b0, 1'b0);
    step(1'b1, 3'b001, 12'o0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b001, 12'o0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bus.ien !== 1'b0) begin bad++; $display("FAIL clr_mid_ien got=%b exp=0", bus.ien); end
    total++; if (bus.pc !== 12'o0202) begin bad++; $display("FAIL clr_mid_pc got=%o exp=%o", bus.pc, 12'o0202); end
    $display("test_clr_mid done pc=%o", bus.pc);
  endtask

  task automatic test_width15;
    bus15.en = 1'b0; bus15.op = 3'b000; bus15.in = '0; bus15.intreq = 1'b0;
    bus15.ionreq = 1'b0; bus15.iofreq = 1'b0; bus15.latch = 1'b0;
    clr15 = 1'b1;
    @(negedge clk);
    clr15 = 1'b0;
    total++; if (bus15.pc !== 15'o00000) begin bad++; $display("FAIL w15_reset got=%o exp=%o", bus15.pc, 15'o00000); end
    bus15.en = 1'b1; bus15.op = 3'b011; bus15.in = 15'o77776;
    @(negedge clk);
    bus15.op = 3'b001;
    @(negedge clk);
    total++; if (bus15.pc !== 15'o77777) begin bad++; $display("FAIL w15_inc got=%o exp=%o", bus15.pc, 15'o77777); end
    @(negedge clk);
    total++; if (bus15.pc !== 15'o00000) begin bad++; $display("FAIL w15_inc_wrap got=%o exp=%o", bus15.pc, 15'o00000); end
    bus15.op = 3'b011; bus15.in = 15'o77777;
    @(negedge clk);
    bus15.op = 3'b010;
    @(negedge clk);
    total++; if (bus15.pc !== 15'o00001) begin bad++; $display("FAIL w15_skip_wrap got=%o exp=%o", bus15.pc, 15'o00001); end
    bus15.op = 3'b100; bus15.in = 15'o77777;
    @(negedge clk);
    total++; if (bus15.pc !== 15'o00000) begin bad++; $display("FAIL w15_loadinc got=%o exp=%o", bus15.pc, 15'o00000); end
    bus15.en = 1'b0;
    $display("test_width15 done pc=%o", bus15.pc);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr   = 1'b0;
    clr15 = 1'b0;
    bus.en = 1'b0; bus.op = 3'b000; bus.in = '0; bus.intreq = 1'b0;
    bus.ionreq = 1'b0; bus.iofreq = 1'b0; bus.latch = 1'b0;
    bus15.en = 1'b0; bus15.op = 3'b000; bus15.in = '0; bus15.intreq = 1'b0;
    bus15.ionreq = 1'b0; bus15.iofreq = 1'b0; bus15.latch = 1'b0;
    @(negedge clk);
    test_reset();
    test_wrap();
    test_en_low();
    test_interrupt();
    test_ion_iof();
    test_clr_mid();
    test_width15();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
